// File: rtl/wb_sram_ctrl_pkg.sv
// Shared definitions for the Wishbone-to-async-SRAM controller: FSM encoding,
// default timing values and the counter-load helper.
package wb_sram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_ACK      = 3'd5
    } state_t;

    localparam logic [31:0] ZeroWord     = 32'h0000_0000;
    localparam int          RD_WAIT_DEF  = 2;
    localparam int          WR_PULSE_DEF = 2;

    // The down-counter expires on zero, so an N-cycle phase loads N-1.
    function automatic logic [3:0] cnt_load(input int n);
        return 4'(n - 1);
    endfunction

endpackage

// File: rtl/wb_sram_ctrl_iobuf.sv
// SRAM data-bus tristate driver and registered read-data capture.
module sram_data_iobuf
    import wb_sram_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        drive_en,
    input  logic [31:0] wdat,
    input  logic        cap_en,
    inout  wire  [31:0] sram_data_io,
    output logic [31:0] rd_data
);

    assign sram_data_io = drive_en ? wdat : {32{1'bz}};

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= ZeroWord;
        end else if (cap_en) begin
            rd_data <= sram_data_io;
        end
    end

endmodule

// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave driving an asynchronous SRAM with programmable read
// wait and write pulse. Optional macro SRAM_POSTED_WRITE_EN acks writes early.
module wb_sram_ctrl
    import wb_sram_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 20,
    parameter int RD_WAIT  = RD_WAIT_DEF,
    parameter int WR_PULSE = WR_PULSE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [31:0]       wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    input  logic [3:0]        wb_sel_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    inout  wire  [31:0]       sram_data_io,
    output logic [3:0]        sram_be_n_o,
    output logic              sram_ce_n_o,
    output logic              sram_oe_n_o,
    output logic              sram_we_n_o,
    output logic              busy_o
);

    state_t      state;
    logic [3:0]  cnt;
    logic        drive_en;
    logic [31:0] wdat;
    logic        cap_en;
    logic        req;
    logic        unused_adr;

    assign req        = wb_cyc_i && wb_stb_i;
    assign cap_en     = (state == ST_RD) && (cnt == 4'd0);
    assign busy_o     = (state != ST_IDLE);
    assign unused_adr = ^{wb_adr_i[31:ADDR_W+2], wb_adr_i[1:0]};

    always_ff @(posedge clk) begin
        if (state == ST_IDLE && req) begin
            wdat <= wb_dat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= 4'd0;
            drive_en    <= 1'b0;
            wb_ack_o    <= 1'b0;
            sram_addr_o <= '0;
            sram_be_n_o <= 4'hF;
            sram_ce_n_o <= 1'b1;
            sram_oe_n_o <= 1'b1;
            sram_we_n_o <= 1'b1;
        end else begin
            wb_ack_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        sram_addr_o <= wb_adr_i[ADDR_W+1:2];
                        sram_be_n_o <= ~wb_sel_i;
                        if (!wb_we_i) begin
                            state       <= ST_RD;
                            sram_ce_n_o <= 1'b0;
                            sram_oe_n_o <= 1'b0;
                            cnt         <= cnt_load(RD_WAIT);
                        end else if (wb_sel_i == 4'b0000) begin
                            // No lanes enabled: acknowledge without touching the SRAM.
                            state    <= ST_ACK;
                            wb_ack_o <= 1'b1;
                        end else begin
                            state       <= ST_WR_SETUP;
                            sram_ce_n_o <= 1'b0;
                            drive_en    <= 1'b1;
`ifdef SRAM_POSTED_WRITE_EN
                            wb_ack_o    <= 1'b1;
`endif
                        end
                    end
                end
                ST_RD: begin
                    if (cnt == 4'd0) begin
                        state       <= ST_ACK;
                        sram_ce_n_o <= 1'b1;
                        sram_oe_n_o <= 1'b1;
                        wb_ack_o    <= wb_cyc_i;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_WR_SETUP: begin
                    state       <= ST_WR_PULSE;
                    sram_we_n_o <= 1'b0;
                    cnt         <= cnt_load(WR_PULSE);
                end
                ST_WR_PULSE: begin
                    if (cnt == 4'd0) begin
                        state       <= ST_WR_HOLD;
                        sram_we_n_o <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_WR_HOLD: begin
                    sram_ce_n_o <= 1'b1;
                    drive_en    <= 1'b0;
`ifdef SRAM_POSTED_WRITE_EN
                    state       <= ST_IDLE;
                    sram_be_n_o <= 4'hF;
`else
                    state       <= ST_ACK;
                    wb_ack_o    <= wb_cyc_i;
`endif
                end
                ST_ACK: begin
                    state       <= ST_IDLE;
                    sram_be_n_o <= 4'hF;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    sram_data_iobuf u_iobuf (
        .clk          (clk),
        .rst          (rst),
        .drive_en     (drive_en),
        .wdat         (wdat),
        .cap_en       (cap_en),
        .sram_data_io (sram_data_io),
        .rd_data      (wb_dat_o)
    );

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Scoreboard bench for wb_sram_ctrl with a behavioural async SRAM model.
module tb_wb_sram_ctrl;

    localparam int ADDR_W = 20;
`ifdef SRAM_POSTED_WRITE_EN
    localparam int WR_LAT  = 1;
    localparam int RAW_LAT = 6;
`else
    localparam int WR_LAT  = 5;
    localparam int RAW_LAT = 3;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
    logic [31:0]       wb_adr = '0, wb_dat = '0;
    logic [3:0]        wb_sel = '0;
    logic [31:0]       wb_dat_o;
    logic              wb_ack;
    logic [ADDR_W-1:0] sram_addr;
    wire  [31:0]       sram_data;
    logic [3:0]        sram_be_n;
    logic              sram_ce_n, sram_oe_n, sram_we_n, busy;

    logic [31:0] mem    [0:255];
    logic [31:0] shadow [0:255];
    logic [31:0] exp_q[$];
    logic [31:0] last_rd;
    int n_cmp = 0, n_err = 0;
    int ce_low = 0, oe_low = 0, we_low = 0;

    always #5 clk = ~clk;

    wb_sram_ctrl #(.ADDR_W(ADDR_W), .RD_WAIT(2), .WR_PULSE(2)) dut (
        .clk(clk), .rst(rst),
        .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we),
        .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_sel_i(wb_sel),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack),
        .sram_addr_o(sram_addr), .sram_data_io(sram_data),
        .sram_be_n_o(sram_be_n), .sram_ce_n_o(sram_ce_n),
        .sram_oe_n_o(sram_oe_n), .sram_we_n_o(sram_we_n),
        .busy_o(busy)
    );

    // Asynchronous SRAM: drives the bus while selected for read, latches lanes while we_n is low.
    assign sram_data = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_addr[7:0]] : {32{1'bz}};

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            for (int b = 0; b < 4; b++) begin
                if (!sram_be_n[b]) mem[sram_addr[7:0]][8*b +: 8] <= sram_data[8*b +: 8];
            end
        end
    end

    always @(negedge clk) begin
        if (!sram_ce_n) ce_low <= ce_low + 1;
        if (!sram_oe_n) oe_low <= oe_low + 1;
        if (!sram_we_n) we_low <= we_low + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic clr_strobes();
        @(negedge clk);
        ce_low = 0; oe_low = 0; we_low = 0;
    endtask

    // One Wishbone transaction; latency counted in cycles after the first edge that sees the request.
    task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int exp_lat, input logic keep,
                       input logic now, input string tag);
        int          lat;
        logic        seen;
        logic [31:0] exp;
        if (!now) @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we;
        wb_adr = adr; wb_dat = dat; wb_sel = sel;
        if (we) begin
            for (int b = 0; b < 4; b++)
                if (sel[b]) shadow[adr[9:2]][8*b +: 8] = dat[8*b +: 8];
        end else begin
            exp_q.push_back(shadow[adr[9:2]]);
        end
        seen = 1'b0;
        lat  = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            lat = n;
            if (wb_ack) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_lat"}, seen ? lat : 32'hFFFF_FFFF, exp_lat);
        chk({tag, "_adr"}, {12'd0, sram_addr}, {12'd0, adr[ADDR_W+1:2]});
        chk({tag, "_be"}, {28'd0, sram_be_n}, {28'd0, ~sel});
        if (!we) begin
            exp = exp_q.pop_front();
            chk({tag, "_dat"}, wb_dat_o, exp);
            last_rd = exp;
        end
        if (!keep) begin
            wb_cyc = 1'b0; wb_stb = 1'b0;
        end
    endtask

    initial begin
        logic ack_seen;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = 32'h5A00_0000 | i;
            shadow[i] = 32'h5A00_0000 | i;
        end
        mem[4] = 32'hDEADBEEF; shadow[4] = 32'hDEADBEEF;
        mem[8] = 32'hAABBCCDD; shadow[8] = 32'hAABBCCDD;

        repeat (3) @(negedge clk);
        chk("rst_ce",   {31'd0, sram_ce_n}, 32'd1);
        chk("rst_oe",   {31'd0, sram_oe_n}, 32'd1);
        chk("rst_we",   {31'd0, sram_we_n}, 32'd1);
        chk("rst_be",   {28'd0, sram_be_n}, 32'hF);
        chk("rst_adr",  {12'd0, sram_addr}, 32'd0);
        chk("rst_dat",  wb_dat_o, 32'd0);
        chk("rst_ack",  {31'd0, wb_ack}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_drv",  {31'd0, dut.drive_en}, 32'd0);
        rst = 1'b0;

        txn(1'b0, 32'h0000_0010, 32'd0, 4'hF, 3, 1'b0, 1'b0, "rd10");

        clr_strobes();
        txn(1'b1, 32'h0000_0020, 32'h12345678, 4'b0011, WR_LAT, 1'b0, 1'b1, "wr20");
        wait_idle("wr20");
        chk("wr20_wepulse", we_low, 32'd2);
        txn(1'b0, 32'h0000_0020, 32'd0, 4'hF, 3, 1'b0, 1'b0, "rb20");

        clr_strobes();
        txn(1'b1, 32'h0000_0024, 32'hFFFF_FFFF, 4'b0000, 1, 1'b0, 1'b1, "wrsel0");
        wait_idle("wrsel0");
        chk("sel0_ce", ce_low, 32'd0);
        chk("sel0_oe", oe_low, 32'd0);
        chk("sel0_we", we_low, 32'd0);
        chk("sel0_hold", wb_dat_o, last_rd);
        txn(1'b0, 32'h0000_0024, 32'd0, 4'hF, 3, 1'b0, 1'b0, "rb24");

        txn(1'b0, 32'h0000_0010, 32'd0, 4'hF, 3, 1'b1, 1'b0, "b2b_rd");
        @(negedge clk);
        chk("b2b_idle", {31'd0, busy}, 32'd0);
        chk("b2b_rel",  {31'd0, dut.drive_en}, 32'd0);
        txn(1'b1, 32'h0000_0030, 32'hCAFEF00D, 4'hF, WR_LAT, 1'b0, 1'b1, "b2b_wr");
        wait_idle("b2b_wr");
        txn(1'b0, 32'h0000_0030, 32'd0, 4'hF, 3, 1'b0, 1'b0, "rb30");

        // Read abandoned by the master: the SRAM cycle finishes but no ack is given.
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h0000_0010; wb_sel = 4'hF;
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        ack_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (wb_ack) ack_seen = 1'b1;
        end
        chk("cycdrop_ack", {31'd0, ack_seen}, 32'd0);
        chk("cycdrop_busy", {31'd0, busy}, 32'd0);
        chk("cycdrop_dat", wb_dat_o, shadow[4]);

        // Reset during the write strobe; the target word is left undefined and not read again.
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1;
        wb_adr = 32'h0000_0040; wb_dat = 32'h1111_1111; wb_sel = 4'hF;
        @(negedge clk);
        @(negedge clk);
        chk("rstwr_pulse", {31'd0, sram_we_n}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rstwr_we",   {31'd0, sram_we_n}, 32'd1);
        chk("rstwr_ce",   {31'd0, sram_ce_n}, 32'd1);
        chk("rstwr_busy", {31'd0, busy}, 32'd0);
        chk("rstwr_drv",  {31'd0, dut.drive_en}, 32'd0);
        chk("rstwr_ack",  {31'd0, wb_ack}, 32'd0);
        rst = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
        ack_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (wb_ack) ack_seen = 1'b1;
        end
        chk("rstwr_noack", {31'd0, ack_seen}, 32'd0);

        txn(1'b1, 32'h0000_0050, 32'h0BADC0DE, 4'hF, WR_LAT, 1'b0, 1'b0, "wr50");
        txn(1'b0, 32'h0000_0050, 32'd0, 4'hF, RAW_LAT, 1'b0, 1'b0, "raw50");

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
